// File: rtl/peak_top3_tracker.sv
// Tracks the three largest samples of each interpolated scan-line frame and publishes
// their sample indices (largest first) with a one-cycle valid pulse at end of frame.
module peak_top3_tracker #(
    parameter int POINT_NUM_X = 240,
    parameter int INSERT_NUM  = 16,
    parameter int SAMPLE_BIT  = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  s_sof,
    input  logic [SAMPLE_BIT-1:0] s_data,
    output logic [31:0]           MaxIndex1,
    output logic [31:0]           MaxIndex2,
    output logic [31:0]           MaxIndex3,
    output logic [SAMPLE_BIT-1:0] MaxValue1,
    output logic                  max_valid,
    output logic                  frame_err,
    output logic [1:0]            o_dbg_state
);

    localparam logic [31:0] FRAME_LEN = 32'(POINT_NUM_X * INSERT_NUM);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Handshake: a sample transfers on a rising edge where s_valid && s_ready;
    // s_ready is low only during reset and in the single DONE cycle.

    state_t                         r_state;
    logic [31:0]                    r_idx;
    logic [2:0][SAMPLE_BIT-1:0]     r_val;
    logic [2:0][31:0]               r_pos;
    logic [2:0]                     r_full;
    logic [31:0]                    r_max_idx1;
    logic [31:0]                    r_max_idx2;
    logic [31:0]                    r_max_idx3;
    logic [SAMPLE_BIT-1:0]          r_max_val1;
    logic                           r_max_valid;
    logic                           r_frame_err;

    state_t                         w_state_nx;
    logic [31:0]                    w_idx_nx;
    logic                           w_hs;
    logic                           w_start;
    logic [31:0]                    w_ins_idx;
    logic [2:0][SAMPLE_BIT-1:0]     w_bval;
    logic [2:0][31:0]               w_bpos;
    logic [2:0]                     w_bfull;
    logic [2:0]                     w_gt;
    logic [2:0][SAMPLE_BIT-1:0]     w_nval;
    logic [2:0][31:0]               w_npos;
    logic [2:0]                     w_nfull;
    logic                           w_load;
    logic                           w_clear;
    logic                           w_publish;
    logic                           w_err;

    assign s_ready = sys_rst_n && (r_state != ST_DONE);

    // Sorted insertion; a start-of-frame sample is inserted into an empty list.
    always_comb begin
        w_hs      = s_valid && s_ready;
        w_start   = w_hs && s_sof;
        w_ins_idx = w_start ? 32'd0 : r_idx;
        w_bval    = r_val;
        w_bpos    = r_pos;
        w_bfull   = w_start ? 3'b000 : r_full;
        for (int k = 0; k < 3; k++) begin
            w_gt[k] = !w_bfull[k] || (s_data > w_bval[k]);
        end
        w_nval  = w_bval;
        w_npos  = w_bpos;
        w_nfull = w_bfull;
        if (w_gt[0]) begin
            w_nval[2]  = w_bval[1];
            w_npos[2]  = w_bpos[1];
            w_nfull[2] = w_bfull[1];
            w_nval[1]  = w_bval[0];
            w_npos[1]  = w_bpos[0];
            w_nfull[1] = w_bfull[0];
            w_nval[0]  = s_data;
            w_npos[0]  = w_ins_idx;
            w_nfull[0] = 1'b1;
        end else if (w_gt[1]) begin
            w_nval[2]  = w_bval[1];
            w_npos[2]  = w_bpos[1];
            w_nfull[2] = w_bfull[1];
            w_nval[1]  = s_data;
            w_npos[1]  = w_ins_idx;
            w_nfull[1] = 1'b1;
        end else if (w_gt[2]) begin
            w_nval[2]  = s_data;
            w_npos[2]  = w_ins_idx;
            w_nfull[2] = 1'b1;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_load     = 1'b0;
        w_clear    = 1'b0;
        w_publish  = 1'b0;
        w_err      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nx = ST_ACC;
                    w_idx_nx   = 32'd1;
                    w_load     = 1'b1;
                end
            end
            ST_ACC: begin
                if (w_hs) begin
                    w_load = 1'b1;
                    if (s_sof) begin
                        w_err    = 1'b1;
                        w_idx_nx = 32'd1;
                    end else begin
                        w_idx_nx = r_idx + 32'd1;
                        // Publish with the last sample already inserted, so the result
                        // appears in the DONE cycle, one cycle after the final handshake.
                        if (r_idx == FRAME_LEN - 32'd1) begin
                            w_state_nx = ST_DONE;
                            w_publish  = 1'b1;
                            w_clear    = 1'b1;
                            w_load     = 1'b0;
                        end
                    end
                end
            end
            ST_DONE: begin
                w_state_nx = ST_IDLE;
                w_idx_nx   = 32'd0;
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_idx_nx   = 32'd0;
                w_clear    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= 32'd0;
            r_val       <= '0;
            r_pos       <= '0;
            r_full      <= 3'b000;
            r_max_idx1  <= 32'd0;
            r_max_idx2  <= 32'd0;
            r_max_idx3  <= 32'd0;
            r_max_val1  <= '0;
            r_max_valid <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_idx       <= w_idx_nx;
            r_max_valid <= w_publish;
            r_frame_err <= w_err;
            if (w_clear) begin
                r_full <= 3'b000;
            end else if (w_load) begin
                r_val  <= w_nval;
                r_pos  <= w_npos;
                r_full <= w_nfull;
            end
            if (w_publish) begin
                r_max_idx1 <= w_npos[0];
                r_max_idx2 <= w_npos[1];
                r_max_idx3 <= w_npos[2];
                r_max_val1 <= w_nval[0];
            end
        end
    end

    assign MaxIndex1   = r_max_idx1;
    assign MaxIndex2   = r_max_idx2;
    assign MaxIndex3   = r_max_idx3;
    assign MaxValue1   = r_max_val1;
    assign max_valid   = r_max_valid;
    assign frame_err   = r_frame_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_peak_top3_tracker.sv
// Bench for peak_top3_tracker: directed frames against a frame-buffer reference that
// ranks each completed frame by a full scan, checked every cycle plus literal pins.
module tb_peak_top3_tracker;

    localparam int FRAME_LEN = 3840;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_sof = 1'b0;
    logic [15:0] s_data = 16'd0;
    logic        s_ready;
    logic [31:0] MaxIndex1, MaxIndex2, MaxIndex3;
    logic [15:0] MaxValue1;
    logic        max_valid, frame_err;
    logic [1:0]  o_dbg_state;

    int total = 0;
    int bad = 0;

    peak_top3_tracker #(.POINT_NUM_X(240), .INSERT_NUM(16), .SAMPLE_BIT(16)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_sof(s_sof), .s_data(s_data), .MaxIndex1(MaxIndex1), .MaxIndex2(MaxIndex2),
        .MaxIndex3(MaxIndex3), .MaxValue1(MaxValue1), .max_valid(max_valid),
        .frame_err(frame_err), .o_dbg_state(o_dbg_state)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: buffer every sample of the current frame; rank when the frame is complete.
    bit          started = 0;
    bit          m_busy = 0;
    bit          m_done = 0;
    logic [15:0] fq[$];
    logic [31:0] e_i1 = 0, e_i2 = 0, e_i3 = 0;
    logic [15:0] e_v1 = 0;
    logic        e_mv = 0, e_fe = 0;

    task automatic rank_frame();
        int pick[3];
        for (int r = 0; r < 3; r++) begin
            int best = -1;
            for (int k = 0; k < fq.size(); k++) begin
                if ((r > 0 && k == pick[0]) || (r > 1 && k == pick[1])) continue;
                if (best < 0 || fq[k] > fq[best]) best = k;
            end
            pick[r] = best;
        end
        e_i1 = 32'(pick[0]);
        e_i2 = 32'(pick[1]);
        e_i3 = 32'(pick[2]);
        e_v1 = fq[pick[0]];
    endtask

    always @(posedge sys_clk) begin
        started = 1;
        e_mv = 0;
        e_fe = 0;
        if (!sys_rst_n) begin
            m_busy = 0;
            m_done = 0;
            fq.delete();
            e_i1 = 0; e_i2 = 0; e_i3 = 0; e_v1 = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (s_valid) begin
            if (s_sof) begin
                if (m_busy) e_fe = 1;
                fq.delete();
                m_busy = 1;
                fq.push_back(s_data);
            end else if (m_busy) begin
                fq.push_back(s_data);
            end
            if (m_busy && fq.size() == FRAME_LEN) begin
                rank_frame();
                e_mv = 1;
                m_done = 1;
                m_busy = 0;
                fq.delete();
            end
        end
    end

    always @(negedge sys_clk) begin
        if (started) begin
            check("s_ready", 32'(s_ready), 32'(sys_rst_n && !m_done));
            check("max_valid", 32'(max_valid), 32'(e_mv));
            check("frame_err", 32'(frame_err), 32'(e_fe));
            check("MaxIndex1", MaxIndex1, e_i1);
            check("MaxIndex2", MaxIndex2, e_i2);
            check("MaxIndex3", MaxIndex3, e_i3);
            check("MaxValue1", 32'(MaxValue1), 32'(e_v1));
        end
    end

    // Returns at #1 after the edge that accepted the sample.
    task automatic send(input logic [15:0] d, input logic sof, input int gap);
        int n = 0;
        while (gap > 0 && $urandom_range(0, 99) < gap) begin
            s_valid = 1'b0;
            @(posedge sys_clk); #1;
        end
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        while (!s_ready && n < 8) begin
            @(posedge sys_clk); #1;
            n++;
        end
        if (n == 8) check("ready_timeout", 32'(s_ready), 32'd1);
        @(posedge sys_clk); #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    function automatic logic [15:0] frame_val(input int kind, input int i);
        case (kind)
            0: return 16'(i);
            1: return (i == 100 || i == 2000) ? 16'd500 : (i == 7) ? 16'd400 : 16'd0;
            2: return 16'h1234;
            default: return (i == 50 || i == 60) ? 16'd9000 : (i == 3000) ? 16'd8999 : 16'd1;
        endcase
    endfunction

    task automatic run_frame(input int kind, input int gap);
        for (int i = 0; i < FRAME_LEN; i++) send(frame_val(kind, i), i == 0, gap);
    endtask

    task automatic pin(input string tag, input logic [31:0] i1, input logic [31:0] i2,
                       input logic [31:0] i3, input logic [31:0] v1);
        check({tag, "_valid"}, 32'(max_valid), 32'd1);
        check({tag, "_idx1"}, MaxIndex1, i1);
        check({tag, "_idx2"}, MaxIndex2, i2);
        check({tag, "_idx3"}, MaxIndex3, i3);
        check({tag, "_val1"}, 32'(MaxValue1), v1);
    endtask

    initial begin
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_ready", 32'(s_ready), 32'd0);
        check("rst_idx1", MaxIndex1, 32'd0);
        check("rst_valid", 32'(max_valid), 32'd0);
        sys_rst_n = 1'b1;

        run_frame(0, 0);
        pin("ramp", 3839, 3838, 3837, 3839);
        repeat (2) @(posedge sys_clk);
        #1;
        check("hold_valid", 32'(max_valid), 32'd0);
        check("hold_idx1", MaxIndex1, 32'd3839);

        run_frame(1, 0);
        pin("sparse", 100, 2000, 7, 500);

        run_frame(2, 0);
        pin("const", 0, 1, 2, 32'h1234);

        run_frame(0, 50);
        pin("gappy", 3839, 3838, 3837, 3839);

        for (int i = 0; i < 1000; i++) send(16'd60000, i == 0, 0);
        for (int j = 0; j < FRAME_LEN; j++) begin
            send(frame_val(3, j), j == 0, 0);
            if (j == 0) begin
                check("early_sof_err", 32'(frame_err), 32'd1);
                check("early_sof_valid", 32'(max_valid), 32'd0);
            end
        end
        pin("resync", 50, 60, 3000, 9000);

        for (int i = 0; i < 20; i++) send(16'd7000, 1'b0, 0);
        for (int i = 0; i < 500; i++) send(16'd65000, i == 0, 0);
        sys_rst_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        check("midrst_idx1", MaxIndex1, 32'd0);
        check("midrst_idx3", MaxIndex3, 32'd0);
        check("midrst_val1", 32'(MaxValue1), 32'd0);
        check("midrst_valid", 32'(max_valid), 32'd0);
        sys_rst_n = 1'b1;
        run_frame(0, 0);
        pin("post_rst", 3839, 3838, 3837, 3839);

        repeat (3) @(posedge sys_clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
